// File: rtl/uart_tx_fifo_if.sv
// Byte-stream handshake feeding the UART transmitter FIFO.
// The producer drives in_data/in_valid; the transmitter answers with in_ready.
interface uart_tx_fifo_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter with a small byte FIFO in front of it.
// ser_tx is a registered copy of the current line level, so it trails the
// FSM state by one clock; every bit therefore still lasts CLKS_PER_BIT cycles.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 106,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    uart_tx_fifo_if.slave                 in_if,
    output logic                          ser_tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CNW = AW + 1;
    localparam int CW  = $clog2(CLKS_PER_BIT);

    localparam logic [CNW-1:0] DEPTH_C   = CNW'(FIFO_DEPTH);
    localparam logic [CNW-1:0] CNT_ZERO  = {CNW{1'b0}};
    localparam logic [CNW-1:0] CNT_ONE   = CNW'(1);
    localparam logic [AW-1:0]  PTR_ZERO  = {AW{1'b0}};
    localparam logic [AW-1:0]  PTR_ONE   = AW'(1);
    localparam logic [CW-1:0]  CYC_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0]  CYC_ONE   = CW'(1);
    localparam logic [CW-1:0]  CYC_LAST  = CW'(CLKS_PER_BIT - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    logic [7:0]     mem_r [FIFO_DEPTH];
    logic [AW-1:0]  wptr_r;
    logic [AW-1:0]  rptr_r;
    logic [CNW-1:0] count_r;
    logic [1:0]     state_r;
    logic [CW-1:0]  cyc_r;
    logic [2:0]     bit_r;
    logic [7:0]     shift_r;
    logic           ser_tx_r;

    logic           ready_s;
    logic           push_s;
    logic           pop_s;
    logic           bit_end_s;
    logic           nonempty_s;

    // Handshake, pop and bit-boundary decisions for the current cycle.
    always_comb begin
        nonempty_s = (count_r != CNT_ZERO);
        bit_end_s  = (cyc_r == CYC_LAST);
        ready_s    = (~reset) & (count_r < DEPTH_C);
        push_s     = in_if.in_valid & ready_s;
        pop_s      = 1'b0;
        case (state_r)
            ST_IDLE: pop_s = nonempty_s;
            ST_STOP: pop_s = bit_end_s & nonempty_s;
            default: pop_s = 1'b0;
        endcase
    end

    // FIFO pointers and occupancy; reset discards anything still queued.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_r  <= PTR_ZERO;
            rptr_r  <= PTR_ZERO;
            count_r <= CNT_ZERO;
        end else begin
            if (push_s) begin
                wptr_r <= wptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rptr_r <= rptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Byte storage; validity is tracked by the pointers, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wptr_r] <= in_if.in_data;
        end
    end

    // Frame sequencer: START, eight DATA bits LSB first, STOP, chaining frames.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            cyc_r   <= CYC_ZERO;
            bit_r   <= 3'd0;
            shift_r <= 8'h00;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    cyc_r <= CYC_ZERO;
                    bit_r <= 3'd0;
                    if (pop_s) begin
                        shift_r <= mem_r[rptr_r];
                        state_r <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_end_s) begin
                        cyc_r   <= CYC_ZERO;
                        bit_r   <= 3'd0;
                        state_r <= ST_DATA;
                    end else begin
                        cyc_r <= cyc_r + CYC_ONE;
                    end
                end
                ST_DATA: begin
                    if (bit_end_s) begin
                        cyc_r   <= CYC_ZERO;
                        shift_r <= {1'b0, shift_r[7:1]};
                        if (bit_r == 3'd7) begin
                            bit_r   <= 3'd0;
                            state_r <= ST_STOP;
                        end else begin
                            bit_r <= bit_r + 3'd1;
                        end
                    end else begin
                        cyc_r <= cyc_r + CYC_ONE;
                    end
                end
                ST_STOP: begin
                    if (bit_end_s) begin
                        cyc_r <= CYC_ZERO;
                        if (pop_s) begin
                            shift_r <= mem_r[rptr_r];
                            state_r <= ST_START;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end else begin
                        cyc_r <= cyc_r + CYC_ONE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cyc_r   <= CYC_ZERO;
                    bit_r   <= 3'd0;
                end
            endcase
        end
    end

    // Registered line driver: level for the state the sequencer is in now.
    always_ff @(posedge clk) begin
        if (reset) begin
            ser_tx_r <= 1'b1;
        end else begin
            case (state_r)
                ST_START: ser_tx_r <= 1'b0;
                ST_DATA:  ser_tx_r <= shift_r[0];
                default:  ser_tx_r <= 1'b1;
            endcase
        end
    end

    assign ser_tx         = ser_tx_r;
    assign busy           = (state_r != ST_IDLE) | nonempty_s;
    assign fifo_count     = count_r;
    assign in_if.in_ready = ready_s;
endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter CLKS_PER_BIT, default 106, clock cycles per serial bit; legal range 2..65535.
REQ-002 Parameter FIFO_DEPTH, default 4, byte entries in the input FIFO; power of 2, minimum 2.
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port in_data  input  8  byte to transmit.
REQ-006 Port in_valid  input  1  in_data is valid this cycle.
REQ-007 Port in_ready  output  1  FIFO can accept a byte this cycle.
REQ-008 Port ser_tx  output  1  serial line; idle high; registered output.
REQ-009 Port busy  output  1  frame in progress or FIFO non-empty.
REQ-010 Port fifo_count  output  $clog2(FIFO_DEPTH)+1  bytes currently held in the FIFO.

Function
REQ-011 Frame format SHALL be 8N1: one start bit (0), eight data bits LSB first, one stop bit (1); no parity.
REQ-012 Each bit, including start and stop, SHALL hold ser_tx constant for exactly CLKS_PER_BIT cycles; full frame = 10*CLKS_PER_BIT cycles.
REQ-013 Push SHALL occur on a rising edge where in_valid && in_ready; in_data is written at the write pointer, and the pointer wraps modulo FIFO_DEPTH.
REQ-014 in_ready SHALL be 1 iff fifo_count < FIFO_DEPTH and reset is low; it depends on registered state only, never on in_valid.
REQ-015 When full, in_ready SHALL be 0 even if a pop occurs in the same cycle; no bypass.
REQ-016 Simultaneous push and pop SHALL leave fifo_count unchanged; both pointers advance.
REQ-017 FSM states SHALL be IDLE, START, DATA, STOP; a bit counter (0..7) and a cycle counter (0..CLKS_PER_BIT-1) are also kept.
REQ-018 IDLE: ser_tx=1; when fifo_count>0, pop the head byte into the shift register and enter START on that edge.
REQ-019 START: ser_tx=0 for CLKS_PER_BIT cycles, then enter DATA with bit counter 0.
REQ-020 DATA: ser_tx = shift[0]; after CLKS_PER_BIT cycles, shift right by one; after bit 7, enter STOP.
REQ-021 STOP: ser_tx=1 for CLKS_PER_BIT cycles. On the final cycle, if fifo_count>0, pop and enter START directly (no idle gap); otherwise enter IDLE.
REQ-022 Latency: a byte accepted at edge N into an empty FIFO with the FSM in IDLE SHALL be popped at edge N+1; ser_tx SHALL be 0 from edge N+2.
REQ-023 busy SHALL be 1 iff state != IDLE or fifo_count != 0.
REQ-024 in_data and in_valid SHALL be ignored whenever in_ready=0; an ignored byte is not stored.

Reset
REQ-025 While reset=1 at a rising edge, all state SHALL clear: state=IDLE, ser_tx=1, fifo_count=0, both pointers=0, counters=0, busy=0, in_ready=0.
REQ-026 Reset asserted mid-frame SHALL drive ser_tx=1 from the next edge, abandon the frame and flush all FIFO contents; no partial frame resumes.
REQ-027 In the first cycle after reset deasserts, in_ready SHALL be 1.

Verification (CLKS_PER_BIT=106, FIFO_DEPTH=4)
REQ-028 Push 0x41 while idle -> ser_tx low 106 cycles, then data 1,0,0,0,0,0,1,0 at 106 cycles each, then high 106 cycles; busy falls 1060 cycles after the start-bit edge.
REQ-029 Push 0x80 -> seven 0 data bits, then a 1 in bit slot 7; a bench sampling at mid-bit decodes 0x80.
REQ-030 Push 6 bytes back-to-back from idle -> bytes 1-5 accepted on consecutive edges, fifo_count reaches 4, in_ready=0; byte 6 is accepted only after byte 2 is popped, 1060 cycles after byte 1's pop.
REQ-031 Push 0x55, then 0xAA during the frame -> the 0xAA start bit immediately follows the 0x55 stop bit with zero idle cycles; 2120 cycles total.
REQ-032 Assert reset for 1 cycle during DATA bit 3 with 2 bytes queued -> ser_tx=1 on the next edge, fifo_count=0, no further frames, in_ready=1 after reset is released.
REQ-033 Hold in_valid=1 while full, changing in_data each cycle -> only bytes presented while in_ready=1 appear on ser_tx, in push order.
